// File: rtl/serial_alu_pkg.sv
// Shared constants for the bit-serial ALU: op codes, FSM state encoding, default width.
package serial_alu_pkg;

    localparam int unsigned DEF_WIDTH = 32;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/serial_alu_slice.sv
// One-bit ALU slice: AND/OR, or full adder with optional B inversion (op[2]).
module serial_alu_slice
    import serial_alu_pkg::*;
(
    input  logic       a_bit,
    input  logic       b_bit,
    input  logic       cin,
    input  logic [2:0] op,
    output logic       sum_c,
    output logic       cout_c
);

    logic b_eff;

    always_comb begin
        b_eff  = b_bit ^ op[2];
        cout_c = (a_bit & b_eff) | (cin & (a_bit ^ b_eff));
        sum_c  = a_bit ^ b_eff ^ cin;
        case (op)
            OP_AND:  sum_c = a_bit & b_bit;
            OP_OR:   sum_c = a_bit | b_bit;
            default: sum_c = a_bit ^ b_eff ^ cin;
        endcase
    end

endmodule

// File: rtl/serial_alu_seq.sv
// Bit-serial ALU: one result bit per cycle, LSB first.
// Optional set-less-than on op 111 enabled by SERIAL_ALU_SLT_EN (otherwise op 111 is SUB).
module serial_alu_seq
    import serial_alu_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   res_sh_q, res_sh_d;
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               zero_q, zero_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;

    logic               slice_sum;
    logic               slice_cout;
    logic [WIDTH-1:0]   full_res;
    logic [WIDTH-1:0]   res_fin;
    logic               is_logic;

    serial_alu_slice u_slice (
        .a_bit  (a_sh_q[0]),
        .b_bit  (b_sh_q[0]),
        .cin    (carry_q),
        .op     (op_q),
        .sum_c  (slice_sum),
        .cout_c (slice_cout)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            op_q     <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            op_q     <= op_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        op_d     = op_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        done_d   = 1'b0;
        busy_d   = busy_q;
        full_res = {slice_sum, res_sh_q[WIDTH-1:1]};
        res_fin  = full_res;
        is_logic = (op_q == OP_AND) || (op_q == OP_OR);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_RUN;
                    a_sh_d   = a;
                    b_sh_d   = b;
                    op_d     = op;
                    cnt_d    = '0;
                    carry_d  = op[2];
                    res_sh_d = '0;
                    busy_d   = 1'b1;
                end
            end
            ST_RUN: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                res_sh_d = full_res;
                carry_d  = slice_cout;
                cnt_d    = cnt_q + CNT_W'(1);
                // Final bit: carry_q is the carry into the MSB, slice_cout the carry out.
                if (cnt_q == LAST_BIT) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    cout_d  = is_logic ? 1'b0 : slice_cout;
                    ovf_d   = is_logic ? 1'b0 : (carry_q ^ slice_cout);
`ifdef SERIAL_ALU_SLT_EN
                    if (op_q == OP_SLT) begin
                        res_fin = {{(WIDTH-1){1'b0}}, slice_sum ^ carry_q ^ slice_cout};
                        cout_d  = 1'b0;
                        ovf_d   = 1'b0;
                    end
`endif
                    result_d = res_fin;
                    zero_d   = (res_fin == '0);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;
    assign zero     = zero_q;

endmodule

// File: tb/tb_serial_alu_seq.sv
// Randomized self-checking bench for serial_alu_seq against an arithmetic reference model.
module tb_serial_alu_seq;

    localparam int unsigned WIDTH = 32;

    logic             clk;
    logic             reset;
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             overflow;
    logic             zero;

    int n_checks = 0;
    int n_pass   = 0;

    serial_alu_seq #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .overflow (overflow),
        .zero     (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain two's-complement arithmetic on wide integers.
    task automatic model(input logic [2:0] o, input logic [31:0] ia, input logic [31:0] ib,
                         output logic [31:0] r, output logic c, output logic v);
        logic [32:0] s;
        logic [31:0] bb;
        if (o == 3'b000) begin
            r = ia & ib; c = 1'b0; v = 1'b0;
        end else if (o == 3'b001) begin
            r = ia | ib; c = 1'b0; v = 1'b0;
        end else begin
            bb = o[2] ? ~ib : ib;
            s  = {1'b0, ia} + {1'b0, bb} + 33'(o[2]);
            r  = s[31:0];
            c  = s[32];
            v  = (ia[31] == bb[31]) && (r[31] != ia[31]);
`ifdef SERIAL_ALU_SLT_EN
            if (o == 3'b111) begin
                r = ($signed(ia) < $signed(ib)) ? 32'd1 : 32'd0;
                c = 1'b0;
                v = 1'b0;
            end
`endif
        end
    endtask

    task automatic run_op(input logic [2:0] o, input logic [31:0] ia, input logic [31:0] ib,
                          input bit disturb, output logic [31:0] r, output logic c,
                          output logic v, output logic z);
        int lat;
        int dones;
        r = '0; c = 1'b0; v = 1'b0; z = 1'b0;
        op = o; a = ia; b = ib; start = 1'b1;
        step();
        start = 1'b0;
        check("busy_after_accept", 64'(busy), 64'd1);
        lat = 0;
        dones = 0;
        for (int k = 1; k <= int'(WIDTH) + 4; k++) begin
            if (disturb && (k == 3 || k == int'(WIDTH) - 2)) begin
                start = 1'b1;
                a = $urandom;
                b = $urandom;
                op = 3'($urandom);
            end else begin
                start = 1'b0;
            end
            step();
            if (done) begin
                dones++;
                if (lat == 0) begin
                    lat = k;
                    r = result; c = cout; v = overflow; z = zero;
                end
            end
        end
        start = 1'b0;
        check("latency", 64'(lat), 64'(WIDTH));
        check("done_count", 64'(dones), 64'd1);
        check("idle_after", 64'(busy), 64'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] r, er;
        logic        c, v, z, ec, ev;
        logic [2:0]  o;
        logic [31:0] ra, rb;
        int          dones;

        reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        repeat (3) step();
        reset = 1'b0;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_flags", 64'({cout, overflow, zero}), 64'd0);

        // Reset wins over a simultaneous start.
        reset = 1'b1; start = 1'b1; op = 3'b010; a = 32'd7; b = 32'd9;
        step();
        reset = 1'b0; start = 1'b0;
        check("rst_prio_busy", 64'(busy), 64'd0);
        step();
        check("rst_prio_busy2", 64'(busy), 64'd0);

        run_op(3'b010, 32'h7FFF_FFFF, 32'd1, 1'b0, r, c, v, z);
        check("add_ovf_result", 64'(r), 64'h8000_0000);
        check("add_ovf_flags", 64'({c, v, z}), 64'b010);

        run_op(3'b110, 32'd5, 32'd5, 1'b0, r, c, v, z);
        check("sub_eq_result", 64'(r), 64'd0);
        check("sub_eq_flags", 64'({c, v, z}), 64'b101);

        run_op(3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, r, c, v, z);
        check("and_result", 64'(r), 64'hF000_F000);
        check("and_flags", 64'({c, v}), 64'd0);

        run_op(3'b001, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, r, c, v, z);
        check("or_result", 64'(r), 64'hFFF0_FFF0);
        check("or_flags", 64'({c, v}), 64'd0);

        run_op(3'b111, 32'hFFFF_FFFF, 32'd1, 1'b0, r, c, v, z);
`ifdef SERIAL_ALU_SLT_EN
        check("slt_result", 64'(r), 64'd1);
        check("slt_flags", 64'({c, v}), 64'd0);
`else
        check("slt_as_sub", 64'(r), 64'hFFFF_FFFE);
        check("slt_as_sub_cout", 64'(c), 64'd1);
`endif

        // Repeated start and operand changes while running.
        run_op(3'b010, 32'd1000, 32'd2345, 1'b1, r, c, v, z);
        check("disturb_result", 64'(r), 64'd3345);

        // Reset partway through an ADD aborts it.
        op = 3'b010; a = 32'h1234_5678; b = 32'h1111_1111; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 10; k++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_result", 64'(result), 64'd0);
        check("abort_flags", 64'({cout, overflow, zero}), 64'd0);
        dones = 0;
        for (int k = 0; k < int'(WIDTH) + 4; k++) begin
            step();
            if (done) dones++;
        end
        check("abort_no_done", 64'(dones), 64'd0);
        run_op(3'b010, 32'd100, 32'd23, 1'b0, r, c, v, z);
        check("after_abort_result", 64'(r), 64'd123);

        for (int i = 0; i < 40; i++) begin
            o  = 3'($urandom);
            ra = pick();
            rb = pick();
            model(o, ra, rb, er, ec, ev);
            run_op(o, ra, rb, ($urandom_range(0, 3) == 0), r, c, v, z);
            check("rnd_result", 64'(r), 64'(er));
            check("rnd_cout", 64'(c), 64'(ec));
            check("rnd_ovf", 64'(v), 64'(ev));
            check("rnd_zero", 64'(z), 64'(er == 32'd0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
